// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the baud divisor helper
// used by both the transmit and receive sides.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_rx_state_t;

    // Clock cycles per bit, rounded to nearest.
    function automatic int uart_divisor(input int clk_freq, input int uart_freq);
        return (clk_freq + uart_freq / 2) / uart_freq;
    endfunction

endpackage

// File: rtl/ip_uart_rx_if.sv
// Byte delivery channel from the UART receiver to its consumer.
interface ip_uart_rx_if;
    logic [7:0] recv_data;
    logic       recv_valid;
    logic       recv_ack;
    logic       recv_frame_err;
    logic       recv_overrun;

    modport master (
        output recv_data,
        output recv_valid,
        output recv_frame_err,
        output recv_overrun,
        input  recv_ack
    );

    modport slave (
        input  recv_data,
        input  recv_valid,
        input  recv_frame_err,
        input  recv_overrun,
        output recv_ack
    );
endinterface

// File: rtl/ip_sync2.sv
// Generic two-flop synchroniser for a single asynchronous input; both flops
// come out of reset at rst_val so an idle line does not look like an edge.
module ip_sync2 #(
    parameter logic rst_val = 1'b1
) (
    input  logic clk,
    input  logic n_reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            meta <= rst_val;
            q    <= rst_val;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/ip_uart_rx.sv
// 8N1 UART receiver: mid-bit sampling via a down-counter that expires at zero,
// byte delivery through a valid/ack handshake with frame-error and overrun pulses.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | line high, waiting for a falling edge on rxs
// START      | half a bit in; confirm start bit is still low (else glitch)
// DATA       | sample 8 data bits, LSB first, one per bit period
// STOP       | sample stop bit; deliver byte or flag framing error
// WAIT_HIGH  | after a framing error, hold off until the line returns high
module ip_uart_rx
    import uart_pkg::*;
#(
    parameter int clk_freq  = 54000000,
    parameter int uart_freq = 115200
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        uart_rx,
    ip_uart_rx_if.master recv
);
    localparam int BIT  = uart_divisor(clk_freq, uart_freq);
    localparam int HALF = BIT / 2;
    localparam int CW   = $clog2(BIT);

    // Loading N-1 and expiring at zero puts the sample N cycles after the load decision.
    localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 1);

    logic           rxs;
    logic           rxs_d;
    uart_rx_state_t state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [7:0]     shreg, shreg_nxt;
    logic [2:0]     idx, idx_nxt;
    logic           tc;
    logic           deliver;
    logic           frame_bad;

    ip_sync2 #(.rst_val(1'b1)) u_sync (
        .clk     (clk),
        .n_reset (n_reset),
        .d       (uart_rx),
        .q       (rxs)
    );

    assign tc = (cnt == '0);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rxs_d <= 1'b1;
            state <= ST_IDLE;
            cnt   <= '0;
            shreg <= '0;
            idx   <= '0;
        end else begin
            rxs_d <= rxs;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        idx_nxt   = idx;
        deliver   = 1'b0;
        frame_bad = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rxs_d && !rxs) begin
                    cnt_nxt   = HALF_LOAD;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (!tc) begin
                    cnt_nxt = cnt - CW'(1);
                end else if (!rxs) begin
                    cnt_nxt   = BIT_LOAD;
                    idx_nxt   = '0;
                    state_nxt = ST_DATA;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!tc) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    shreg_nxt = {rxs, shreg[7:1]};
                    cnt_nxt   = BIT_LOAD;
                    idx_nxt   = idx + 3'd1;
                    if (idx == 3'd7)
                        state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (!tc) begin
                    cnt_nxt = cnt - CW'(1);
                end else if (rxs) begin
                    deliver   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    frame_bad = 1'b1;
                    state_nxt = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (rxs)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // An ack landing in the delivery cycle frees the slot, so the new byte wins.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            recv.recv_data      <= 8'h00;
            recv.recv_valid     <= 1'b0;
            recv.recv_frame_err <= 1'b0;
            recv.recv_overrun   <= 1'b0;
        end else begin
            recv.recv_frame_err <= frame_bad;
            recv.recv_overrun   <= 1'b0;
            if (deliver) begin
                if (!recv.recv_valid || recv.recv_ack) begin
                    recv.recv_data  <= shreg;
                    recv.recv_valid <= 1'b1;
                end else begin
                    recv.recv_overrun <= 1'b1;
                end
            end else if (recv.recv_ack) begin
                recv.recv_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/ip_uart_rx.md
# ip_uart_rx

Asynchronous 8N1 serial receiver. It is the receive-side counterpart of `ip_uart`. It synchronises the `uart_rx` pin, detects and validates start bits, and samples 8 data bits LSB-first at mid-bit. Each completed byte is presented to the consumer (for example `ip_debugger` command input) through a valid/ack handshake, with framing-error and overrun reporting.

## Interface
Parameters:
- `clk_freq`, 54000000 — system clock frequency, Hz.
- `uart_freq`, 115200 — baud rate, bits/s.

Ports:
- `clk`  in  1 — system clock. One clock domain only; all logic is on its rising edge.
- `n_reset`  in  1 — asynchronous, active-low reset.
- `uart_rx`  in  1 — serial line. Asynchronous to `clk`; idles high.
- `recv_data`  out  8 — last accepted byte. Stable while `recv_valid`=1.
- `recv_valid`  out  1 — byte available. Level signal, held until acknowledged.
- `recv_ack`  in  1 — consumer acknowledge. A 1-cycle pulse clears `recv_valid`.
- `recv_frame_err`  out  1 — 1-cycle pulse when the stop bit is sampled low.
- `recv_overrun`  out  1 — 1-cycle pulse when a byte completes while `recv_valid`=1.

## Operation
- **Divisor and counter:**
  - BIT = round(`clk_freq`/`uart_freq`), which is 469 at the defaults.
  - HALF = BIT/2 truncated, which is 234.
  - The counter width is clog2(BIT).
- **Synchroniser:** 2-flop synchroniser on `uart_rx`, both flops reset to 1. `rxs` is the second-flop output. `rxs_d` is `rxs` delayed one cycle, reset to 1.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when `rxs_d`=1 and `rxs`=0 (falling edge), load the counter with HALF and go to START.
  - START: when the counter expires, sample `rxs`.
    - `rxs`=0: load BIT, clear the bit index, go to DATA.
    - `rxs`=1: glitch. Return to IDLE with no output.
  - DATA: on each expiry, shift `rxs` into bit [7] of the shift register (right shift, LSB first) and reload BIT. After the 8th sample, go to STOP.
  - STOP: on expiry, sample `rxs`.
    - `rxs`=1: deliver the byte (see handshake rules) and go to IDLE.
    - `rxs`=0: pulse `recv_frame_err`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`=1, then go to IDLE. This prevents a held-low/break line from retriggering.
- **Handshake rules:**
  - Delivery with `recv_valid`=0: `recv_data` ← shift register, `recv_valid` ← 1.
  - Delivery with `recv_valid`=1 and no `recv_ack` that cycle: keep the old byte, drop the new one, pulse `recv_overrun`.
  - Delivery in the same cycle as `recv_ack`: the ack is consumed and the new byte is loaded. `recv_valid` stays 1 and no overrun is reported.
  - `recv_ack` while `recv_valid`=0 is ignored.
- **Reset:**
  - Reset values: `recv_data`=0x00, `recv_valid`=0, `recv_frame_err`=0, `recv_overrun`=0, FSM=IDLE, counter=0, shift register=0.
  - Reset asserted mid-frame aborts the frame with no output pulse.
  - A line already low at reset release appears as a falling edge. That frame ends in a framing error followed by WAIT_HIGH; this is the required behaviour.

## Timing
- t0 is the first cycle with `rxs`=0 while IDLE. The pin-to-`rxs` delay is 2 cycles.
- Sample times:
  - Start bit at t0+HALF.
  - Data bit k (k=0..7) at t0+HALF+BIT·(k+1).
  - Stop bit at t0+HALF+9·BIT, which is t0+4455 at the defaults.
- `recv_valid`, `recv_frame_err` and `recv_overrun` are registered. They change in the cycle after the stop-bit sample.
- Back-to-back frames: IDLE is re-entered right after the stop sample, about HALF cycles before the nominal end of the stop bit. A start edge immediately after the stop bit is therefore caught.
- Baud tolerance: ±2% against the sender still samples within the bit.

## Structure
- Package `uart_pkg`:
  - state enum `uart_rx_state_t`
  - function `uart_divisor(clk_freq, uart_freq)` with rounding, shared with `ip_uart`
- Sub-module `ip_sync2`: generic 2-flop synchroniser with a reset-value parameter (set to 1 here). It is reusable for the `keys` inputs.
- Everything else (FSM, counter, shift register, output register) lives in `ip_uart_rx`.

## Test plan
Drive the line from a bench serial model at 54 MHz / 115200 unless stated otherwise.
- **Single byte:** send 0xA5 and hold `recv_ack`=0 → `recv_valid`=1 with `recv_data`=0xA5, rising exactly 4456 cycles after t0. Pulse `recv_ack` → `recv_valid` is 0 on the next cycle.
- **Glitch:** a 100-cycle low pulse on an idle line → no `recv_valid` and no error; FSM back in IDLE.
- **Framing error:** send 0x3C with a low stop bit, then hold low for 2000 cycles → one `recv_frame_err` pulse, `recv_valid` stays 0, no retrigger. After the line goes high, 0x55 is received correctly.
- **Overrun:** send 0x11 then 0x22 back-to-back with no ack → `recv_data`=0x11 and one `recv_overrun` pulse. After ack, send 0x33 → `recv_data`=0x33.
- **Ack collision:** send 0x11; pulse `recv_ack` exactly in the cycle the 0x22 stop bit is sampled → `recv_valid` stays 1, `recv_data`=0x22, no overrun.
- **Reset and baud skew:** assert `n_reset` mid-frame (after bit 3) → all outputs at reset values and no pulse. Then send 0x00, 0xFF and 0x5A at baud +2% and −2% → all three received correctly.
